// File: rtl/ym3438_write_sched.sv
// ---------------------------------------------------------------------------
// ym3438_write_sched
//
// Buffers host register writes (bank, address, data) in a FIFO and replays
// each one onto the ym3438 bus pins as an address phase followed by a data
// phase. Each phase drives a write pulse of PULSE cycles, then holds CS high
// for a fixed busy wait, so the host never polls the chip status register.
// With ADDR_CACHE=1, the address phase is skipped when bank and address
// match the last address written.
//
// Ports:
//   MCLK        master clock, rising edge
//   IC          asynchronous active-low reset (shared with the chip IC pin)
//   req_valid   host write request; accepted when req_ready is 1
//   req_ready   FIFO has room (count != DEPTH)
//   req_bank    register bank (0 or 1)
//   req_addr    register address
//   req_data    register data
//   count       FIFO occupancy
//   idle        FIFO empty and scheduler idle
//   ym_cs       chip CS, active low
//   ym_wr       chip WR, active low
//   ym_rd       chip RD, tied high
//   ym_address  chip ADDRESS[1:0] = {bank, data_phase}
//   ym_data     chip DATA_i
// ---------------------------------------------------------------------------
module ym3438_write_sched #(
    parameter int DEPTH      = 8,
    parameter int PULSE      = 4,
    parameter int WAIT_ADDR  = 24,
    parameter int WAIT_DATA  = 192,
    parameter int ADDR_CACHE = 1
) (
    input  logic                   MCLK,
    input  logic                   IC,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_bank,
    input  logic [7:0]             req_addr,
    input  logic [7:0]             req_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   idle,
    output logic                   ym_cs,
    output logic                   ym_wr,
    output logic                   ym_rd,
    output logic [1:0]             ym_address,
    output logic [7:0]             ym_data
);

    localparam int AW       = $clog2(DEPTH);
    localparam int MAX_AD   = (WAIT_ADDR > WAIT_DATA) ? WAIT_ADDR : WAIT_DATA;
    localparam int MAX_WAIT = (PULSE > MAX_AD) ? PULSE : MAX_AD;
    localparam int CW       = $clog2(MAX_WAIT + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP, A_PULSE, A_HOLD, A_WAIT,
        D_SETUP, D_PULSE, D_HOLD, D_WAIT
    } state_t;

    // FIFO entry layout: {bank, addr[7:0], data[7:0]}
    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [16:0]   head;
    logic          push, pop, dispatch, cache_hit;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          work_bank;
    logic [7:0]    work_addr, work_data;
    logic          cache_valid, cache_bank;
    logic [7:0]    cache_addr;
    logic          src_bank;
    logic [7:0]    src_addr, src_data;

    assign req_ready = (count != FULL);
    assign push      = req_valid && req_ready;
    assign head      = mem[rd_ptr];
    assign idle      = (state == IDLE) && (count == '0);
    assign ym_rd     = 1'b1;
    assign cache_hit = (ADDR_CACHE != 0) && cache_valid &&
                       ({cache_bank, cache_addr} == head[16:8]);

    // On a pop edge the pins must already show the new entry, so the
    // output decode reads the FIFO head instead of the working registers.
    assign src_bank = pop ? head[16]    : work_bank;
    assign src_addr = pop ? head[15:8]  : work_addr;
    assign src_data = pop ? head[7:0]   : work_data;

    // NOTE: storage has no reset; only the pointers and count define which
    // entries are valid, so clearing the array would buy nothing.
    always_ff @(posedge MCLK) begin
        if (push) mem[wr_ptr] <= {req_bank, req_addr, req_data};
    end

    // NOTE: every register is updated with <= so all flops sample the same
    // pre-edge values regardless of statement order.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next-state logic. The wait counter is loaded on entry to PULSE/WAIT
    // and a state exits on the cycle it observes zero.
    // NOTE: nxt/cnt_nxt/pop/dispatch get defaults first so no path leaves
    // them unassigned, which would otherwise infer latches.
    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        pop      = 1'b0;
        dispatch = 1'b0;
        case (state)
            IDLE:    dispatch = 1'b1;
            A_SETUP: begin nxt = A_PULSE; cnt_nxt = CW'(PULSE - 1); end
            A_PULSE: if (cnt == '0) nxt = A_HOLD; else cnt_nxt = cnt - 1'b1;
            A_HOLD:  if (WAIT_ADDR == 0) nxt = D_SETUP;
                     else begin nxt = A_WAIT; cnt_nxt = CW'(WAIT_ADDR - 1); end
            A_WAIT:  if (cnt == '0) nxt = D_SETUP; else cnt_nxt = cnt - 1'b1;
            D_SETUP: begin nxt = D_PULSE; cnt_nxt = CW'(PULSE - 1); end
            D_PULSE: if (cnt == '0) nxt = D_HOLD; else cnt_nxt = cnt - 1'b1;
            D_HOLD:  if (WAIT_DATA == 0) dispatch = 1'b1;
                     else begin nxt = D_WAIT; cnt_nxt = CW'(WAIT_DATA - 1); end
            D_WAIT:  if (cnt == '0) dispatch = 1'b1; else cnt_nxt = cnt - 1'b1;
            default: nxt = IDLE;
        endcase
        // Back-to-back writes skip IDLE entirely.
        if (dispatch) begin
            if (count != '0) begin
                pop = 1'b1;
                nxt = cache_hit ? D_SETUP : A_SETUP;
            end else begin
                nxt = IDLE;
            end
        end
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            state       <= IDLE;
            cnt         <= '0;
            work_bank   <= 1'b0;
            work_addr   <= '0;
            work_data   <= '0;
            cache_valid <= 1'b0;
            cache_bank  <= 1'b0;
            cache_addr  <= '0;
            ym_cs       <= 1'b1;
            ym_wr       <= 1'b1;
            ym_address  <= '0;
            ym_data     <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (pop) begin
                work_bank <= head[16];
                work_addr <= head[15:8];
                work_data <= head[7:0];
            end
            // The chip has latched the address once A_HOLD completes.
            if (state == A_HOLD) begin
                cache_valid <= 1'b1;
                cache_bank  <= work_bank;
                cache_addr  <= work_addr;
            end
            ym_cs <= !(nxt inside {A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD});
            ym_wr <= !(nxt inside {A_PULSE, D_PULSE});
            case (nxt)
                A_SETUP, A_PULSE, A_HOLD, A_WAIT: begin
                    ym_address <= {src_bank, 1'b0};
                    ym_data    <= src_addr;
                end
                D_SETUP, D_PULSE, D_HOLD, D_WAIT: begin
                    ym_address <= {src_bank, 1'b1};
                    ym_data    <= src_data;
                end
                default: ;  // IDLE: bus keeps its last value
            endcase
        end
    end

endmodule

// File: tb/tb_ym3438_write_sched.sv
// ---------------------------------------------------------------------------
// tb_ym3438_write_sched
//
// Two instances with small timing parameters: one with the address cache
// enabled (main), one with it disabled (nc). Pin activity is observed on the
// falling clock edge; every ym_wr fall is logged as {ym_address, ym_data}
// and CS/WR run lengths are measured for comparison against expected values.
// ---------------------------------------------------------------------------
module tb_ym3438_write_sched;

    localparam int DEPTH     = 4;
    localparam int PULSE     = 2;
    localparam int WAIT_ADDR = 3;
    localparam int WAIT_DATA = 5;
    localparam int CNTW      = $clog2(DEPTH) + 1;

    logic            MCLK, IC;
    logic            m_valid, n_valid, req_bank;
    logic [7:0]      req_addr, req_data;

    logic            req_ready, idle, ym_cs, ym_wr, ym_rd;
    logic [1:0]      ym_address;
    logic [7:0]      ym_data;
    logic [CNTW-1:0] count;

    logic            n_ready, n_idle, n_cs, n_wr, n_rd;
    logic [1:0]      n_address;
    logic [7:0]      n_data;
    logic [CNTW-1:0] n_count;

    ym3438_write_sched #(
        .DEPTH(DEPTH), .PULSE(PULSE), .WAIT_ADDR(WAIT_ADDR),
        .WAIT_DATA(WAIT_DATA), .ADDR_CACHE(1)
    ) dut (
        .MCLK(MCLK), .IC(IC), .req_valid(m_valid), .req_ready(req_ready),
        .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data),
        .count(count), .idle(idle), .ym_cs(ym_cs), .ym_wr(ym_wr), .ym_rd(ym_rd),
        .ym_address(ym_address), .ym_data(ym_data)
    );

    ym3438_write_sched #(
        .DEPTH(DEPTH), .PULSE(PULSE), .WAIT_ADDR(WAIT_ADDR),
        .WAIT_DATA(WAIT_DATA), .ADDR_CACHE(0)
    ) dut_nc (
        .MCLK(MCLK), .IC(IC), .req_valid(n_valid), .req_ready(n_ready),
        .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data),
        .count(n_count), .idle(n_idle), .ym_cs(n_cs), .ym_wr(n_wr), .ym_rd(n_rd),
        .ym_address(n_address), .ym_data(n_data)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    int total = 0;
    int bad   = 0;

    // Pin observer state (written only from the main initial via tasks)
    logic [9:0] log_m[$], log_n[$], exp_m[$], exp_n[$];
    int         cs_runs[$], wr_runs[$], gaps[$], idle_q[$];
    logic       pcs = 1'b1, pwr = 1'b1, pidle = 1'b1, pnwr = 1'b1;
    logic [9:0] prev_ad = '0;
    int         cs_len = 0, wr_len = 0, hi_len = 0, since_rise = 0, stab_err = 0;
    bit         hi_on = 1'b0;

    typedef struct {
        logic       bank;
        logic [7:0] addr;
        logic [7:0] data;
        logic       addr_phase;   // expected address phase on the cached instance
    } row_t;

    row_t rows[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ent(input logic b, input logic ph, input logic [7:0] v);
        return {b, ph, v};
    endfunction

    task automatic sample();
        logic [9:0] ad;
        ad = {ym_address, ym_data};
        if (!IC) begin
            pcs = 1'b1; pwr = 1'b1; pidle = 1'b1; pnwr = 1'b1;
            cs_len = 0; wr_len = 0; hi_on = 1'b0; prev_ad = ad;
            return;
        end
        if (pwr && !ym_wr) begin
            log_m.push_back(ad);
            if (ad != prev_ad) stab_err++;   // setup cycle before WR falls
        end
        if (!pwr && ym_wr && ad != prev_ad) stab_err++;  // hold cycle after WR rises
        if (!ym_wr) wr_len++;
        else if (!pwr) begin wr_runs.push_back(wr_len); wr_len = 0; end
        if (!ym_cs) begin
            if (pcs && hi_on) gaps.push_back(hi_len);
            hi_on = 1'b0;
            cs_len++;
        end else if (!pcs) begin
            cs_runs.push_back(cs_len);
            cs_len = 0; hi_on = 1'b1; hi_len = 1; since_rise = 0;
        end else begin
            hi_len++;
            since_rise++;
        end
        if (idle && !pidle) idle_q.push_back(since_rise);
        if (pnwr && !n_wr) log_n.push_back({n_address, n_data});
        pcs = ym_cs; pwr = ym_wr; pidle = idle; pnwr = n_wr; prev_ad = ad;
    endtask

    task automatic tick();
        @(negedge MCLK);
        sample();
    endtask

    task automatic clear_logs();
        log_m.delete(); log_n.delete(); exp_m.delete(); exp_n.delete();
        cs_runs.delete(); wr_runs.delete(); gaps.delete(); idle_q.delete();
        hi_on = 1'b0;
    endtask

    task automatic push(input logic b, input logic [7:0] a, input logic [7:0] d,
                        input bit to_m, input bit to_n);
        req_bank = b; req_addr = a; req_data = d;
        m_valid = to_m; n_valid = to_n;
        tick();
        m_valid = 1'b0; n_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(idle && n_idle) && n < max_cycles);
        check(name, {31'd0, idle && n_idle}, 32'd1);
    endtask

    task automatic cmp_log(input string name, input bit use_n);
        logic [9:0] act[$], exp[$];
        act = use_n ? log_n : log_m;
        exp = use_n ? exp_n : exp_m;
        check({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_%0d", name, i),
                  (i < act.size()) ? {22'd0, act[i]} : 32'hFFFF_FFFF, {22'd0, exp[i]});
    endtask

    initial begin
        int idx, first_reassert, full_err;
        bit saw_full, was_ready;

        rows[0] = '{1'b0, 8'h28, 8'h11, 1'b0};  // cached from the single write
        rows[1] = '{1'b1, 8'h28, 8'h12, 1'b1};  // same address, other bank
        rows[2] = '{1'b1, 8'h29, 8'h13, 1'b1};
        rows[3] = '{1'b1, 8'h29, 8'hFF, 1'b0};
        rows[4] = '{1'b0, 8'h29, 8'h00, 1'b1};
        rows[5] = '{1'b0, 8'h29, 8'h7E, 1'b0};

        IC = 1'b0; m_valid = 1'b0; n_valid = 1'b0;
        req_bank = 1'b0; req_addr = '0; req_data = '0;

        // ---- reset ----
        repeat (3) tick();
        check("rst_cs", {31'd0, ym_cs}, 32'd1);
        check("rst_wr", {31'd0, ym_wr}, 32'd1);
        check("rst_rd", {31'd0, ym_rd}, 32'd1);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_bus", {22'd0, ym_address, ym_data}, 32'd0);
        IC = 1'b1;
        tick();

        // ---- single write with exact latency ----
        clear_logs();
        push(1'b0, 8'h28, 8'hF0, 1'b1, 1'b0);            // pushed at edge E
        check("lat_e0_cs", {31'd0, ym_cs}, 32'd1);
        check("lat_e0_count", {29'd0, count}, 32'd1);
        check("lat_e0_idle", {31'd0, idle}, 32'd0);
        tick();                                          // after E+1: address setup
        check("lat_e1_cs", {31'd0, ym_cs}, 32'd0);
        check("lat_e1_wr", {31'd0, ym_wr}, 32'd1);
        check("lat_e1_bus", {22'd0, ym_address, ym_data}, {22'd0, ent(1'b0, 1'b0, 8'h28)});
        tick();                                          // after E+2: WR low
        check("lat_e2_wr", {31'd0, ym_wr}, 32'd0);
        wait_idle("single_done", 100);
        exp_m.push_back(ent(1'b0, 1'b0, 8'h28));
        exp_m.push_back(ent(1'b0, 1'b1, 8'hF0));
        cmp_log("single_log", 1'b0);
        check("single_cs_runs", cs_runs.size(), 2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("single_cs_low%0d", i), (i < cs_runs.size()) ? cs_runs[i] : -1, PULSE + 2);
            check($sformatf("single_wr_low%0d", i), (i < wr_runs.size()) ? wr_runs[i] : -1, PULSE);
        end
        check("single_gap", (gaps.size() > 0) ? gaps[0] : -1, WAIT_ADDR);
        // Edges from the final CS rise to idle rising: D_WAIT length.
        check("single_idle_delay", (idle_q.size() > 0) ? idle_q[0] : -1, WAIT_DATA);

        // ---- table: cache hits and misses on both instances ----
        foreach (rows[r]) begin
            clear_logs();
            push(rows[r].bank, rows[r].addr, rows[r].data, 1'b1, 1'b1);
            wait_idle($sformatf("row%0d_done", r), 200);
            if (rows[r].addr_phase) exp_m.push_back(ent(rows[r].bank, 1'b0, rows[r].addr));
            exp_m.push_back(ent(rows[r].bank, 1'b1, rows[r].data));
            exp_n.push_back(ent(rows[r].bank, 1'b0, rows[r].addr));
            exp_n.push_back(ent(rows[r].bank, 1'b1, rows[r].data));
            cmp_log($sformatf("row%0d_m", r), 1'b0);
            cmp_log($sformatf("row%0d_n", r), 1'b1);
            check($sformatf("row%0d_cs_low", r), (cs_runs.size() > 0) ? cs_runs[0] : -1, PULSE + 2);
            check($sformatf("row%0d_wr_low", r), (wr_runs.size() > 0) ? wr_runs[0] : -1, PULSE);
        end

        // ---- cache: back-to-back writes to the same register ----
        clear_logs();
        push(1'b1, 8'hA4, 8'h22, 1'b1, 1'b1);
        push(1'b1, 8'hA4, 8'h33, 1'b1, 1'b1);
        wait_idle("cache_done", 200);
        exp_m.push_back(ent(1'b1, 1'b0, 8'hA4));
        exp_m.push_back(ent(1'b1, 1'b1, 8'h22));
        exp_m.push_back(ent(1'b1, 1'b1, 8'h33));
        exp_n.push_back(ent(1'b1, 1'b0, 8'hA4));
        exp_n.push_back(ent(1'b1, 1'b1, 8'h22));
        exp_n.push_back(ent(1'b1, 1'b0, 8'hA4));
        exp_n.push_back(ent(1'b1, 1'b1, 8'h33));
        cmp_log("cache_m", 1'b0);
        cmp_log("cache_n", 1'b1);
        // CS-high cycles between the first data phase and the cached one.
        check("cache_gap", (gaps.size() > 1) ? gaps[1] : -1, WAIT_DATA);

        // ---- full FIFO with req_valid held ----
        clear_logs();
        idx = 0; saw_full = 1'b0; full_err = 0; first_reassert = -1;
        for (int cyc = 0; cyc < 500 && idx < DEPTH + 2; cyc++) begin
            req_bank = idx[0]; req_addr = 8'h30 + 8'(idx); req_data = 8'h80 + 8'(idx);
            m_valid = 1'b1;
            was_ready = req_ready;
            tick();
            if (was_ready) idx++;
            if ((count == CNTW'(DEPTH)) == req_ready) full_err++;
            if (count == CNTW'(DEPTH)) saw_full = 1'b1;
            if (!was_ready && req_ready && first_reassert < 0) first_reassert = int'(count);
        end
        m_valid = 1'b0;
        check("full_accepted", idx, DEPTH + 2);
        check("full_reached", {31'd0, saw_full}, 32'd1);
        check("full_ready_vs_count", full_err, 0);
        check("full_reassert_count", first_reassert, DEPTH - 1);
        wait_idle("full_done", 1000);
        for (int i = 0; i < DEPTH + 2; i++) begin
            exp_m.push_back(ent(i[0], 1'b0, 8'h30 + 8'(i)));
            exp_m.push_back(ent(i[0], 1'b1, 8'h80 + 8'(i)));
        end
        cmp_log("full_order", 1'b0);
        check("stability", stab_err, 0);

        // ---- reset during the data pulse with 3 entries queued ----
        clear_logs();
        push(1'b0, 8'h50, 8'h01, 1'b1, 1'b0);
        push(1'b0, 8'h51, 8'h02, 1'b1, 1'b0);
        push(1'b0, 8'h52, 8'h03, 1'b1, 1'b0);
        push(1'b0, 8'h53, 8'h04, 1'b1, 1'b0);
        idx = 0;
        while (!(!ym_wr && ym_address[0]) && idx < 100) begin
            tick();
            idx++;
        end
        check("mid_reached_dpulse", {31'd0, !ym_wr && ym_address[0]}, 32'd1);
        check("mid_queued", {29'd0, count}, 32'd3);
        #2 IC = 1'b0;
        #1;
        check("mid_cs", {31'd0, ym_cs}, 32'd1);
        check("mid_wr", {31'd0, ym_wr}, 32'd1);
        check("mid_rd", {31'd0, ym_rd}, 32'd1);
        check("mid_count", {29'd0, count}, 32'd0);
        check("mid_bus", {22'd0, ym_address, ym_data}, 32'd0);
        check("mid_idle", {31'd0, idle}, 32'd1);
        repeat (3) tick();
        IC = 1'b1;
        tick();
        clear_logs();
        push(1'b0, 8'h50, 8'h99, 1'b1, 1'b0);            // would hit a stale cache
        wait_idle("post_rst_done", 200);
        exp_m.push_back(ent(1'b0, 1'b0, 8'h50));
        exp_m.push_back(ent(1'b0, 1'b1, 8'h99));
        cmp_log("post_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
